ahfp_pipeline_delay: RTL
========================

# ahfp_pipeline_delay

Parametrised, stallable, flushable delay line for the AHFP datapath. It is the successor to the fixed `STAGES`/`WIDTH` pipeline buffer. It carries a valid tag per stage, honours a global pipeline enable (stall), clears in-flight items on flush, and selects the output tap at run time so one instance can match several arithmetic-unit latencies. It sits beside AHFP arithmetic units to align side-band operands and control with the unit's result.

## Interface
Parameters:
- `WIDTH`, 32, data width in bits (>=1)
- `STAGES`, 10, maximum delay in clock cycles (>=1)
- `SEL_W`, `$clog2(STAGES+1)`, width of `depth_sel` and `inflight`

Ports:
- `clk`  in  1  rising-edge clock; the only clock
- `rst_n`  in  1  reset, asynchronous and active-low
- `en`  in  1  pipeline enable; 0 = stall, all stages hold
- `flush`  in  1  clear every valid tag (synchronous)
- `in_valid`  in  1  qualifies `in_data`
- `in_data`  in  WIDTH  input word
- `depth_sel`  in  SEL_W  delay in enabled cycles; legal 1..STAGES
- `out_valid`  out  1  valid tag at the selected tap
- `out_data`  out  WIDTH  data at the selected tap
- `inflight`  out  SEL_W  count of valid items in stages 0..depth-1

## Operation
- Stage registers `data[0..STAGES-1]` and `valid[0..STAGES-1]`.
- Reset (`rst_n`=0, any time, asynchronous): all `data` = 0 and all `valid` = 0. Outputs are therefore `out_valid`=0, `out_data`=0, `inflight`=0. Reset mid-stream discards everything.
- `en`=1, `flush`=0: `data[0]<=in_data`, `valid[0]<=in_valid`, and `data[i+1]<=data[i]`, `valid[i+1]<=valid[i]`. Data shifts even when its valid tag is 0.
- `en`=0, `flush`=0: all registers hold, and `in_*` is ignored.
- `flush`=1: all `valid` <= 0 on the next edge regardless of `en`. `in_valid` that cycle is dropped (flush wins). `data` registers still shift if `en`=1, otherwise they hold.
- Effective depth d = `depth_sel` if 1 <= `depth_sel` <= STAGES. A value of 0 or anything above STAGES clamps to STAGES.
- `out_data` = `data[d-1]` and `out_valid` = `valid[d-1]`. This is a combinational mux from registers; there is no extra register.
- `inflight` = popcount(`valid[0..d-1]`), combinational. It reaches STAGES when every selected stage is valid, and never wraps.
- Changing `depth_sel` takes effect on the output immediately. Items between the old and new tap are re-emitted or skipped. This is legal only when `inflight`=0 or in the same cycle as `flush`. The block does not detect misuse.

## Timing
- Latency: a word accepted at enabled edge k appears at the output after d enabled edges. Stall cycles add one cycle each.
- `depth_sel`=1: output follows `data[0]`, i.e. one-cycle latency. There is no combinational in->out path for any setting.
- Throughput: one word per enabled cycle, with no bubbles inserted.
- Flush: `out_valid`=0 and `inflight`=0 from the edge after `flush` until new valid data reaches the tap.
- Simultaneous `en`=0 and `flush`=1: tags clear and data holds.
- Critical path: STAGES:1 tap mux plus the popcount adder tree.

## Structure
- Package `ahfp_pipeline_pkg` holds:
  - default `WIDTH`/`STAGES` constants
  - function `ahfp_clamp_depth(sel, stages)` returning the effective d
  - function `ahfp_popcount`
- Sub-module `ahfp_pipeline_stage`: one `WIDTH`-bit data register plus its valid register, with `en`, `flush` and async `rst_n`. It is instantiated STAGES times in a generate loop.
- The top level adds the tap mux and the `inflight` popcount only.

## Test plan
- **Reset and basic latency.** Assert `rst_n`=0 mid-run → all outputs read 0 immediately. After release, with `en`=1 and `depth_sel`=10, feed `in_data`=1,2,3… with `in_valid`=1 → `out_data`=1 with `out_valid`=1 exactly 10 cycles after the first input, and `inflight`=10 in steady state.
- **Tap select.** With `depth_sel`=1, 4 and 10 (STAGES=10), inject single word 0xA5A5A5A5 → `out_valid` pulses for one cycle at latency 1, 4 and 10 respectively. With `depth_sel`=0 and 15 → latency is 10.
- **Stall.** Inject word 0x11 at cycle 0 with `depth_sel`=4, then drive `en`=0 for 3 cycles at cycle 2 → output appears at cycle 7 and no other words change.
- **Flush.** With 5 valid words in flight, pulse `flush` together with `in_valid`=1 → next cycle `inflight`=0 and `out_valid` stays 0 for d cycles. The word presented during flush never appears.
- **Bubbles and flush during stall.** Use the alternating `in_valid` pattern 1,0,1,0 with `depth_sel`=3 → `out_valid` reproduces 1,0,1,0 delayed by 3 and `inflight` toggles 1/2. Then drive `flush`=1 with `en`=0 → tags clear and `out_data` holds its value.
- **Width.** Run with `WIDTH`=1 and `STAGES`=1 → the block builds, latency is 1, and `inflight` is 0/1.

Source files
------------

// File: rtl/ahfp_pipeline_pkg.sv
// Shared constants and helpers for the AHFP delay line.
package ahfp_pipeline_pkg;

  // Defaults used when an instance does not override the parameters.
  localparam int AHFP_DEFAULT_WIDTH  = 32;
  localparam int AHFP_DEFAULT_STAGES = 10;

  // Upper bound on STAGES; also sets the width of the popcount argument.
  localparam int AHFP_MAX_STAGES = 256;

  // Effective tap depth: a selector of 0 or above the stage count
  // falls back to the full depth.
  function automatic int ahfp_clamp_depth(input int sel, input int stages);
    if ((sel >= 1) && (sel <= stages)) begin
      return sel;
    end
    return stages;
  endfunction

  // Number of set bits in a tag vector. Unused upper bits must be zero.
  function automatic int ahfp_popcount(input logic [AHFP_MAX_STAGES-1:0] bits);
    int count;
    count = 0;
    for (int i = 0; i < AHFP_MAX_STAGES; i++) begin
      if (bits[i]) begin
        count = count + 1;
      end
    end
    return count;
  endfunction

endpackage

// File: rtl/ahfp_pipeline_stage.sv
// One delay-line stage: a data register plus its valid tag.
// Data moves whenever the pipeline is enabled, even with a zero tag.
// Flush clears the tag regardless of enable and beats the incoming tag.
module ahfp_pipeline_stage
  import ahfp_pipeline_pkg::*;
#(
  parameter int WIDTH = AHFP_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Data register: shifts on enable, holds on stall, zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (en) begin
      out_data <= in_data;
    end
  end

  // Valid tag: flush clears it, otherwise it follows data on enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/ahfp_pipeline_delay.sv
// Stallable, flushable delay line with a run-time selectable output tap.
//
// Handshake: in_valid qualifies in_data and out_valid qualifies out_data.
// There is no ready; the line accepts one word on every enabled edge and
// never back-pressures. en=0 freezes every stage together, and in_* is
// ignored while stalled.
//
// Output and inflight are combinational from the stage registers only,
// so there is no in->out combinational path for any depth setting.
// depth_sel may only change while inflight is 0 or together with flush;
// otherwise words between the old and new tap are skipped or repeated.
module ahfp_pipeline_delay
  import ahfp_pipeline_pkg::*;
#(
  parameter int WIDTH  = AHFP_DEFAULT_WIDTH,
  parameter int STAGES = AHFP_DEFAULT_STAGES,
  parameter int SEL_W  = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] depth_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] inflight
);

  logic [WIDTH-1:0]           stage_data  [STAGES];
  logic                       stage_valid [STAGES];
  logic [AHFP_MAX_STAGES-1:0] tap_mask;
  int                         depth;

  // Stage chain: stage 0 takes the input port, each later stage takes
  // the previous one.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      ahfp_pipeline_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (stage_valid[i]),
        .out_data  (stage_data[i])
      );
    end else begin : g_body
      ahfp_pipeline_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (stage_valid[i-1]),
        .in_data   (stage_data[i-1]),
        .out_valid (stage_valid[i]),
        .out_data  (stage_data[i])
      );
    end
  end

  // Effective depth after clamping out-of-range selectors.
  assign depth = ahfp_clamp_depth(int'(depth_sel), STAGES);

  // Tap mux: pick stage depth-1.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (i == depth - 1) begin
        out_data  = stage_data[i];
        out_valid = stage_valid[i];
      end
    end
  end

  // Occupancy: count valid tags in the selected stages 0..depth-1.
  always_comb begin
    tap_mask = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (i < depth) begin
        tap_mask[i] = stage_valid[i];
      end
    end
    inflight = SEL_W'(ahfp_popcount(tap_mask));
  end

endmodule
